// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: LANES element pairs per beat, registered lane
// multipliers, a registered pairwise adder tree and a per-vector accumulator.
// A result that cannot be emitted because the previous one is still pending
// freezes the whole pipeline, so no data is ever dropped.
module dot_product_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 8,
  parameter int unsigned MAX_LEN    = 256,
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(MAX_LEN) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] in_a,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] in_b,
  input  logic [LANES-1:0]                 in_keep,
  input  logic                             in_last,
  input  logic                             in_signed,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic                             out_err
);

  localparam int Levels    = $clog2(LANES);
  localparam int MaxBeats  = MAX_LEN / LANES;
  localparam int CntWidth  = $clog2(MaxBeats + 1);
  localparam int ProdWidth = 2 * DATA_WIDTH + 2;
  // One spare column so the odd pass-through element never indexes out of range
  localparam int PadLanes  = LANES + 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef enum logic [0:0] {StFirst, StMid} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                  mode_q, mode_d, mode_eff;
  logic                  accept, at_max, beat_last, beat_err, stall;

  acc_t                  lane_prod [LANES];
  acc_t                  tree_q [Levels+1][PadLanes];
  acc_t                  tree_d [Levels+1][PadLanes];
  logic [Levels:0]       vld_q, vld_d, last_q, last_d, err_q, err_d;

  acc_t                  acc_q, acc_d, acc_sum, res_q, res_d;
  logic                  res_err_q, res_err_d, out_valid_q, out_valid_d;

  // Only a completing vector can collide with a pending result
  assign stall    = out_valid_q && !out_ready && vld_q[Levels] && last_q[Levels];
  assign in_ready = reset && !stall;
  assign accept   = in_valid && in_ready;

  // Beat counting, forced termination at MAX_LEN and per-vector mode selection
  always_comb begin
    cnt_inc   = (state_q == StFirst) ? CntWidth'(1) : cnt_q + CntWidth'(1);
    at_max    = (cnt_inc == CntWidth'(MaxBeats));
    beat_last = in_last || at_max;
    beat_err  = at_max && !in_last;
    mode_eff  = (state_q == StFirst) ? in_signed : mode_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    if (accept) begin
      state_d = beat_last ? StFirst : StMid;
      cnt_d   = cnt_inc;
      mode_d  = mode_eff;
    end
  end

  // Each operand widened by one bit so both modes share one signed multiplier
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_WIDTH:0]  a_ext, b_ext;
    logic signed [ProdWidth-1:0] prod;
    assign a_ext        = {mode_eff & in_a[i][DATA_WIDTH-1], in_a[i]};
    assign b_ext        = {mode_eff & in_b[i][DATA_WIDTH-1], in_b[i]};
    assign prod         = a_ext * b_ext;
    assign lane_prod[i] = in_keep[i] ? acc_t'(prod) : '0;
  end

  // Next values of the product stage, adder tree levels and token side-band
  always_comb begin
    int n;
    for (int l = 0; l <= Levels; l++) begin
      for (int i = 0; i < PadLanes; i++) begin
        tree_d[l][i] = '0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      tree_d[0][i] = lane_prod[i];
    end
    for (int l = 1; l <= Levels; l++) begin
      n = (LANES + (1 << (l - 1)) - 1) >> (l - 1);
      for (int i = 0; i < (LANES + 1) / 2; i++) begin
        if (2 * i + 1 < n) begin
          tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
        end else if (2 * i < n) begin
          tree_d[l][i] = tree_q[l-1][2*i];
        end
      end
    end
    vld_d[0]  = accept;
    last_d[0] = beat_last;
    err_d[0]  = beat_err;
    for (int l = 1; l <= Levels; l++) begin
      vld_d[l]  = vld_q[l-1];
      last_d[l] = last_q[l-1];
      err_d[l]  = err_q[l-1];
    end
  end

  // Accumulate tree sums; a last token publishes the total and restarts at zero
  always_comb begin
    acc_sum     = acc_q + tree_q[Levels][0];
    acc_d       = acc_q;
    res_d       = res_q;
    res_err_d   = res_err_q;
    out_valid_d = out_valid_q && !out_ready;
    if (vld_q[Levels] && !stall) begin
      if (last_q[Levels]) begin
        res_d       = acc_sum;
        res_err_d   = err_q[Levels];
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Input FSM registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFirst;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Product and tree stages advance together unless the pipeline is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l <= Levels; l++) begin
        for (int i = 0; i < PadLanes; i++) begin
          tree_q[l][i] <= '0;
        end
      end
      vld_q  <= '0;
      last_q <= '0;
      err_q  <= '0;
    end else if (!stall) begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  // Accumulator and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign out_err   = res_err_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Scoreboard bench for dot_product_stream: stimulus pushes hand-computed
// results into a queue, an independent monitor pops and compares each result.
module tb_dot_product_stream;

  localparam int DW = 16;
  localparam int LN = 8;
  localparam int ML = 256;
  localparam int AW = 2 * DW + $clog2(ML) + 1;

  typedef logic [LN-1:0][DW-1:0] lanes_t;
  typedef struct packed {
    logic [AW-1:0] data;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  lanes_t        in_a = '0;
  lanes_t        in_b = '0;
  logic [LN-1:0] in_keep = '0;
  logic          in_last = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic          out_err;

  res_t          exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  int            pop_cyc = 0;
  int            prev_pop_cyc = 0;

  dot_product_stream #(
    .DATA_WIDTH(DW),
    .LANES     (LN),
    .MAX_LEN   (ML)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_keep  (in_keep),
    .in_last  (in_last),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running, required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic lanes_t fill(input logic [DW-1:0] v);
    lanes_t r;
    for (int i = 0; i < LN; i++) r[i] = v;
    return r;
  endfunction

  task automatic expect_res(input longint v, input logic e);
    res_t r;
    r.data = AW'(v);
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Present one beat; returns 1ns after the edge that accepted it
  task automatic beat(input lanes_t a, input lanes_t b, input logic [LN-1:0] keep,
                      input logic last, input logic sgn, output int waited);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_keep   = keep;
    in_last   = last;
    in_signed = sgn;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL beat_timeout: actual in_ready=0, required in_ready=1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", 64'(n < 300), 64'd1);
  endtask

  // Monitor: pop on every accepted result and check hold stability under backpressure
  logic          hold_vld = 1'b0;
  logic [AW-1:0] hold_data;
  logic          hold_err;
  always @(negedge clk) begin
    res_t e;
    if (!reset) begin
      hold_vld = 1'b0;
    end else begin
      if (out_valid && hold_vld) begin
        check("hold_data", 64'(out_data), 64'(hold_data));
        check("hold_err", 64'(out_err), 64'(hold_err));
      end
      if (out_valid && out_ready) begin
        hold_vld = 1'b0;
        prev_pop_cyc = pop_cyc;
        pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: actual data %0h, required no result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("result_data", 64'(out_data), 64'(e.data));
          check("result_err", 64'(out_err), 64'(e.err));
        end
      end else if (out_valid) begin
        hold_vld  = 1'b1;
        hold_data = out_data;
        hold_err  = out_err;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    int w;
    lanes_t ramp;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single signed beat, ramp times two, with latency check
    for (int i = 0; i < LN; i++) ramp[i] = DW'(i + 1);
    expect_res(72, 1'b0);
    beat(ramp, fill(16'd2), 8'hFF, 1'b1, 1'b1, w);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_on_time", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();

    // Extreme operands in both modes, a negative result, and mode latched on first beat
    expect_res(64'd34359738368, 1'b0);
    for (int k = 0; k < 4; k++) beat(fill(16'h8000), fill(16'h8000), 8'hFF, k == 3, 1'b1, w);
    expect_res(64'd137434759200, 1'b0);
    for (int k = 0; k < 4; k++) beat(fill(16'hFFFF), fill(16'hFFFF), 8'hFF, k == 3, 1'b0, w);
    expect_res(-24, 1'b0);
    beat(fill(16'hFFFF), fill(16'd3), 8'hFF, 1'b1, 1'b1, w);
    expect_res(1048560, 1'b0);
    beat(fill(16'hFFFF), fill(16'd1), 8'hFF, 1'b0, 1'b0, w);
    beat(fill(16'hFFFF), fill(16'd1), 8'hFF, 1'b1, 1'b1, w);
    idle();
    drain();

    // Back-to-back vectors with no bubble
    expect_res(16, 1'b0);
    expect_res(24, 1'b0);
    beat(fill(16'd1), fill(16'd1), 8'hFF, 1'b0, 1'b1, w);
    check("b2b_ready_0", 64'(w), 64'd0);
    beat(fill(16'd1), fill(16'd1), 8'hFF, 1'b1, 1'b1, w);
    check("b2b_ready_1", 64'(w), 64'd0);
    beat(fill(16'd1), fill(16'd3), 8'hFF, 1'b1, 1'b1, w);
    check("b2b_ready_2", 64'(w), 64'd0);
    idle();
    drain();
    check("b2b_slot_gap", 64'(pop_cyc - prev_pop_cyc), 64'd1);

    // Backpressure: results held, input stalls, nothing lost after release
    out_ready = 1'b0;
    fork
      begin
        int wk;
        for (int k = 1; k <= 6; k++) begin
          expect_res(40 * k, 1'b0);
          beat(fill(16'd1), fill(DW'(5 * k)), 8'hFF, 1'b1, 1'b0, wk);
        end
        idle();
      end
      begin
        repeat (10) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_data", 64'(out_data), 64'd40);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Length overflow: 32 beats forced last with error, beat 33 is a new vector
    expect_res(256, 1'b1);
    expect_res(8, 1'b0);
    for (int k = 1; k <= 33; k++) beat(fill(16'd1), fill(16'd1), 8'hFF, k == 33, 1'b0, w);
    idle();
    drain();

    // Reset mid-vector discards the partial sum
    beat(fill(16'd1), fill(16'd1), 8'hFF, 1'b0, 1'b1, w);
    beat(fill(16'd1), fill(16'd1), 8'hFF, 1'b0, 1'b1, w);
    idle();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    expect_res(4, 1'b0);
    beat(fill(16'd1), fill(16'd1), 8'h0F, 1'b1, 1'b1, w);
    idle();
    drain();
    repeat (10) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
- Streaming, fully pipelined dot-product engine for vectors of any length up to MAX_LEN, fed LANES element pairs per beat.
- Successor to the fixed 32-element dot product: arbitrary lane count, variable vector length, a signed/unsigned mode, valid/ready backpressure and a length-overflow flag.
- Sits between the matmul operand staging buffers and the result store.
- One result per vector. Back-to-back vectors are accepted with no bubble.

Parameters:
- DATA_WIDTH, 16, operand element width.
- LANES, 8, element pairs per beat; any value ≥1, power of two not required.
- MAX_LEN, 256, maximum elements per vector; multiple of LANES.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_LEN)+1, result width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts the beat this cycle.
- in_a  in  [LANES][DATA_WIDTH]  operand A lanes.
- in_b  in  [LANES][DATA_WIDTH]  operand B lanes.
- in_keep  in  LANES  per-lane enable; a lane with keep=0 contributes 0.
- in_last  in  1  final beat of the vector.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the first beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  dot product, sign-extended (signed mode) or zero-extended (unsigned mode).
- out_err  out  1  vector was truncated at MAX_LEN.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline registers, the accumulator, the beat counter and the mode register clear.
  - out_valid=0, out_data=0, out_err=0, in_ready=0 while reset is asserted; in_ready goes to 1 on the first cycle after release.
  - Any partial vector is discarded; no result is emitted for it.
- Handshake:
  - A beat transfers when in_valid&&in_ready.
  - A result transfers when out_valid&&out_ready.
  - out_data and out_err are held stable while out_valid=1 and out_ready=0.
- Stall:
  - stall = out_valid && !out_ready && (a last-beat token is at the accumulate stage).
  - in_ready = !stall.
  - A stall freezes every stage; no data is lost or duplicated.
- Pipeline (advances when not stalled):
  - Stage 0: registered lane products. Each operand is extended to DATA_WIDTH+1 bits (sign- or zero-extension per mode), giving signed products of 2*DATA_WIDTH+2 bits. keep=0 forces the product to 0.
  - Stages 1..ceil(log2 LANES): registered pairwise adder tree. An odd element passes through to the next stage.
  - Final stage: accumulator. acc_next = acc + tree_sum. On a last token the result register loads acc_next, out_valid=1, and acc clears to 0 in the same cycle.
  - Latency from the accepted last beat to out_valid = ceil(log2 LANES)+2 cycles with no stall. LANES=8 gives 5; LANES=1 gives 2.
  - Throughput is one beat per cycle.
- Input FSM:
  - FIRST: waiting for the first beat of a vector. On transfer, latch in_signed into the mode register and set the beat counter to 1. Go to MID, or stay in FIRST if in_last=1 (single-beat vector).
  - MID: each transfer increments the counter. in_last returns to FIRST.
  - in_signed is ignored in MID. The mode travels with each beat token, so vectors of different modes can be in flight at the same time.
- Overflow:
  - If a transfer makes the counter equal MAX_LEN/LANES while in_last=0, that beat is forced last and the result carries out_err=1.
  - Following beats start a new vector.
  - Otherwise out_err=0.
- Result register:
  - A result completing while the previous result is still unaccepted cannot occur, because the stall above prevents it.
  - A result completing in the same cycle the previous result is accepted replaces it, keeping out_valid=1.
- Arithmetic:
  - Performed internally at full precision in ACC_WIDTH.
  - No saturation is needed: ACC_WIDTH bounds MAX_LEN worst-case products in both modes.

Test Plan:
- LANES=8, signed, one beat: a=1..8, b=all 2, last=1 → out_data=72 five cycles later, out_err=0.
- Signed, 4 beats, a=-32768 all lanes, b=-32768 all lanes → out_data=32×2^30=34359738368. Same vector in unsigned mode with a=b=0xFFFF → 32×4294836225.
- Two back-to-back vectors, in_valid held at 1: vector 1 all products 1 over 2 beats, vector 2 all products 3 over 1 beat → results 16 then 24 on consecutive result slots; in_ready never drops.
- Hold out_ready=0 for 10 cycles while streaming → in_ready=0 once the second result completes; out_data stays stable; after release both results appear in order, none lost.
- Stream 33 beats with in_last=0 (MAX_LEN=256) → result after beat 32 with out_err=1; beat 33 with in_last=1 yields a separate result with out_err=0.
- Assert reset mid-vector after 2 beats; release; send a one-beat vector with in_keep=8'h0F, a=b=1 → only out_data=4 is seen, with no stale partial result.
